// File: rtl/xgemac_tx_pkt_arbiter.sv
// Round-robin arbiter of NUM_CH packet channels onto the XGEMAC pkt_tx interface.
// The grant changes only on packet boundaries, and the word sent to the MAC is registered.
module xgemac_tx_pkt_arbiter #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 64,
    parameter int MOD_W  = 3,
    parameter int CNT_W  = 16,
    localparam int CH_W  = $clog2(NUM_CH)
) (
    input  logic                      clk_156m25,
    input  logic                      reset_156m25,
    input  logic [NUM_CH-1:0]         ch_val,
    input  logic [NUM_CH-1:0]         ch_sop,
    input  logic [NUM_CH-1:0]         ch_eop,
    input  logic [NUM_CH*MOD_W-1:0]   ch_mod,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    output logic [NUM_CH-1:0]         ch_rdy,
    output logic                      pkt_tx_val,
    output logic                      pkt_tx_sop,
    output logic                      pkt_tx_eop,
    output logic [MOD_W-1:0]          pkt_tx_mod,
    output logic [DATA_W-1:0]         pkt_tx_data,
    input  logic                      pkt_tx_full,
    output logic                      grant_vld,
    output logic [CH_W-1:0]           grant_ch,
    output logic                      err_nosop,
    output logic                      err_sop,
    output logic [NUM_CH*CNT_W-1:0]   pkt_cnt
);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Returns {found, index} of the first requester after 'last', wrapping; the
    // loop runs backwards so the nearest requester is the final assignment.
    function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                              input logic [CH_W-1:0]   last);
        logic [CH_W:0] res;
        int            idx;
        res = '0;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_CH;
            if (req[CH_W'(idx)]) res = {1'b1, CH_W'(idx)};
            else                 res = res;
        end
        return res;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [CH_W-1:0]     last_grant_r, grant_ch_r;
    logic                grant_vld_r, first_word_r;
    logic [CH_W:0]       pick_s;
    logic [NUM_CH-1:0]   rdy_s;
    logic                xfer_s, drop_s;
    logic                sel_sop_s, sel_eop_s;
    logic [MOD_W-1:0]    sel_mod_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                tx_val_r, tx_sop_r, tx_eop_r;
    logic [MOD_W-1:0]    tx_mod_r;
    logic [DATA_W-1:0]   tx_data_r;
    logic                err_nosop_r, err_sop_r;
    logic [NUM_CH*CNT_W-1:0] pkt_cnt_r;

    assign pick_s     = rr_pick(ch_val & ch_sop, last_grant_r);
    assign sel_sop_s  = ch_sop[grant_ch_r];
    assign sel_eop_s  = ch_eop[grant_ch_r];
    assign sel_mod_s  = ch_mod[int'(grant_ch_r)*MOD_W +: MOD_W];
    assign sel_data_s = ch_data[int'(grant_ch_r)*DATA_W +: DATA_W];

    // State register.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) state_r <= IDLE;
        else              state_r <= state_nxt_s;
    end

    // Next state, per-channel ready, transfer and drop qualifiers.
    always_comb begin
        state_nxt_s = state_r;
        rdy_s       = '0;
        xfer_s      = 1'b0;
        drop_s      = 1'b0;
        case (state_r)
            IDLE: begin
                // Stray mid-packet words are swallowed so they cannot block a channel.
                rdy_s  = ch_val & ~ch_sop;
                drop_s = |(ch_val & ~ch_sop);
                if (pick_s[CH_W]) state_nxt_s = BUSY;
                else              state_nxt_s = IDLE;
            end
            BUSY: begin
                rdy_s[grant_ch_r] = ~pkt_tx_full;
                xfer_s            = ch_val[grant_ch_r] & ~pkt_tx_full;
                if (xfer_s && sel_eop_s) state_nxt_s = IDLE;
                else                     state_nxt_s = BUSY;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    assign ch_rdy = reset_156m25 ? '0 : rdy_s;

    // Grant bookkeeping, MAC-side output word, error pulses and packet counters.
    always_ff @(posedge clk_156m25) begin
        if (reset_156m25) begin
            last_grant_r <= CH_W'(NUM_CH - 1);
            grant_ch_r   <= '0;
            grant_vld_r  <= 1'b0;
            first_word_r <= 1'b0;
            tx_val_r     <= 1'b0;
            tx_sop_r     <= 1'b0;
            tx_eop_r     <= 1'b0;
            tx_mod_r     <= '0;
            tx_data_r    <= '0;
            err_nosop_r  <= 1'b0;
            err_sop_r    <= 1'b0;
            pkt_cnt_r    <= '0;
        end else begin
            tx_val_r    <= xfer_s;
            err_nosop_r <= drop_s;
            err_sop_r   <= xfer_s & sel_sop_s & ~first_word_r;
            if (xfer_s) begin
                tx_sop_r  <= sel_sop_s;
                tx_eop_r  <= sel_eop_s;
                tx_mod_r  <= sel_eop_s ? sel_mod_s : '0;
                tx_data_r <= sel_data_s;
            end
            if (state_r == IDLE && pick_s[CH_W]) begin
                grant_ch_r   <= pick_s[CH_W-1:0];
                grant_vld_r  <= 1'b1;
                first_word_r <= 1'b1;
            end else if (xfer_s) begin
                first_word_r <= 1'b0;
                if (sel_eop_s) begin
                    last_grant_r <= grant_ch_r;
                    grant_vld_r  <= 1'b0;
                    pkt_cnt_r[int'(grant_ch_r)*CNT_W +: CNT_W] <=
                        pkt_cnt_r[int'(grant_ch_r)*CNT_W +: CNT_W] + CNT_W'(1'b1);
                end
            end
        end
    end

    assign pkt_tx_val  = tx_val_r;
    assign pkt_tx_sop  = tx_sop_r;
    assign pkt_tx_eop  = tx_eop_r;
    assign pkt_tx_mod  = tx_mod_r;
    assign pkt_tx_data = tx_data_r;
    assign grant_vld   = grant_vld_r;
    assign grant_ch    = grant_ch_r;
    assign err_nosop   = err_nosop_r;
    assign err_sop     = err_sop_r;
    assign pkt_cnt     = pkt_cnt_r;

endmodule

// File: tb/tb_xgemac_tx_pkt_arbiter.sv
// Directed table-driven bench for xgemac_tx_pkt_arbiter (4 channels, 64-bit data).
// Each row: inputs for one cycle, expected ch_rdy that cycle, expected registered outputs after the edge.
module tb_xgemac_tx_pkt_arbiter;

    logic          clk_156m25 = 1'b0;
    logic          reset_156m25;
    logic [3:0]    ch_val, ch_sop, ch_eop, ch_rdy;
    logic [11:0]   ch_mod;
    logic [255:0]  ch_data;
    logic          pkt_tx_val, pkt_tx_sop, pkt_tx_eop, pkt_tx_full;
    logic [2:0]    pkt_tx_mod;
    logic [63:0]   pkt_tx_data;
    logic          grant_vld, err_nosop, err_sop;
    logic [1:0]    grant_ch;
    logic [63:0]   pkt_cnt;

    always #5 clk_156m25 = ~clk_156m25;

    xgemac_tx_pkt_arbiter #(.NUM_CH(4), .DATA_W(64), .MOD_W(3), .CNT_W(16)) dut (
        .clk_156m25(clk_156m25), .reset_156m25(reset_156m25),
        .ch_val(ch_val), .ch_sop(ch_sop), .ch_eop(ch_eop), .ch_mod(ch_mod), .ch_data(ch_data),
        .ch_rdy(ch_rdy), .pkt_tx_val(pkt_tx_val), .pkt_tx_sop(pkt_tx_sop), .pkt_tx_eop(pkt_tx_eop),
        .pkt_tx_mod(pkt_tx_mod), .pkt_tx_data(pkt_tx_data), .pkt_tx_full(pkt_tx_full),
        .grant_vld(grant_vld), .grant_ch(grant_ch), .err_nosop(err_nosop), .err_sop(err_sop),
        .pkt_cnt(pkt_cnt)
    );

    typedef struct {
        int rst, val, sop, eop, mod, dat, full;
        int rdy, tv, ts, te, tm, dch, dd, gv, gch, nos, es;
        logic [63:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [63:0] C1 = 64'h0000_0000_0001_0000;
    localparam logic [63:0] C2 = 64'h0000_0000_0001_0001;
    localparam logic [63:0] C3 = 64'h0001_0000_0001_0001;
    localparam logic [63:0] R1 = 64'h0000_0000_0000_0001;
    localparam logic [63:0] R2 = 64'h0000_0000_0001_0001;
    localparam logic [63:0] R3 = 64'h0000_0001_0001_0001;
    localparam logic [63:0] R4 = 64'h0001_0001_0001_0001;

    function automatic logic [63:0] mk(input int ch, input int d);
        return {8'(ch), 40'h0, 16'(d)};
    endfunction

    task automatic add(input int rst, val, sop, eop, mod, dat, full,
                       input int rdy, tv, ts, te, tm, dch, dd, gv, gch, nos, es,
                       input logic [63:0] cnt);
        vec_t v;
        v.rst = rst; v.val = val; v.sop = sop; v.eop = eop; v.mod = mod; v.dat = dat; v.full = full;
        v.rdy = rdy; v.tv = tv; v.ts = ts; v.te = te; v.tm = tm; v.dch = dch; v.dd = dd;
        v.gv = gv; v.gch = gch; v.nos = nos; v.es = es; v.cnt = cnt;
        vecs.push_back(v);
    endtask

    task automatic drive(input int rst, val, sop, eop, mod, dat, full);
        reset_156m25 = rst[0];
        ch_val       = 4'(val);
        ch_sop       = 4'(sop);
        ch_eop       = 4'(eop);
        pkt_tx_full  = full[0];
        for (int i = 0; i < 4; i++) begin
            ch_mod[i*3 +: 3]   = 3'(mod);
            ch_data[i*64 +: 64] = mk(i, dat);
        end
    endtask

    task automatic check(input string name, input int row, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s row=%0d got=%0h exp=%0h", name, row, act, exp);
        end
    endtask

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0);
        //   rst val sop eop mod dat full | rdy tv ts te tm dch dd gv gch nos es cnt
        add(1, 'h0, 'h0, 'h0, 0, 0, 0,    'h0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 64'h0);
        // channel 1, three-word packet
        add(0, 'h2, 'h2, 'h0, 0, 1, 0,    'h0, 0, 0, 0, 0, 0, 0,  1, 1, 0, 0, 64'h0);
        add(0, 'h2, 'h2, 'h0, 0, 1, 0,    'h2, 1, 1, 0, 0, 1, 1,  1, 1, 0, 0, 64'h0);
        add(0, 'h2, 'h0, 'h0, 5, 2, 0,    'h2, 1, 0, 0, 0, 1, 2,  1, 1, 0, 0, 64'h0);
        add(0, 'h2, 'h0, 'h2, 5, 3, 0,    'h2, 1, 0, 1, 5, 1, 3,  0, 1, 0, 0, C1);
        add(0, 'h0, 'h0, 'h0, 0, 0, 0,    'h0, 0, 0, 1, 5, 1, 3,  0, 1, 0, 0, C1);
        // channel 2 word without sop while idle
        add(0, 'h4, 'h0, 'h0, 0, 7, 0,    'h4, 0, 0, 1, 5, 1, 3,  0, 1, 1, 0, C1);
        add(0, 'h0, 'h0, 'h0, 0, 0, 0,    'h0, 0, 0, 1, 5, 1, 3,  0, 1, 0, 0, C1);
        // channel 0, five words, second sop on word 3
        add(0, 'h1, 'h1, 'h0, 0, 9, 0,    'h0, 0, 0, 1, 5, 1, 3,  1, 0, 0, 0, C1);
        add(0, 'h1, 'h1, 'h0, 0, 10, 0,   'h1, 1, 1, 0, 0, 0, 10, 1, 0, 0, 0, C1);
        add(0, 'h1, 'h0, 'h0, 0, 11, 0,   'h1, 1, 0, 0, 0, 0, 11, 1, 0, 0, 0, C1);
        add(0, 'h1, 'h1, 'h0, 0, 12, 0,   'h1, 1, 1, 0, 0, 0, 12, 1, 0, 0, 1, C1);
        add(0, 'h1, 'h0, 'h0, 0, 13, 0,   'h1, 1, 0, 0, 0, 0, 13, 1, 0, 0, 0, C1);
        add(0, 'h1, 'h0, 'h1, 3, 14, 0,   'h1, 1, 0, 1, 3, 0, 14, 0, 0, 0, 0, C2);
        add(0, 'h0, 'h0, 'h0, 0, 0, 0,    'h0, 0, 0, 1, 3, 0, 14, 0, 0, 0, 0, C2);
        // channel 3, eight words with four cycles of backpressure after word 4
        add(0, 'h8, 'h8, 'h0, 0, 20, 0,   'h0, 0, 0, 1, 3, 0, 14, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h8, 'h0, 0, 21, 0,   'h8, 1, 1, 0, 0, 3, 21, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h0, 'h0, 0, 22, 0,   'h8, 1, 0, 0, 0, 3, 22, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h0, 'h0, 0, 23, 0,   'h8, 1, 0, 0, 0, 3, 23, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h0, 'h0, 0, 24, 0,   'h8, 1, 0, 0, 0, 3, 24, 1, 3, 0, 0, C2);
        for (int k = 0; k < 4; k++)
            add(0, 'h8, 'h0, 'h0, 0, 25, 1, 'h0, 0, 0, 0, 0, 3, 24, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h0, 'h0, 0, 25, 0,   'h8, 1, 0, 0, 0, 3, 25, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h0, 'h0, 0, 26, 0,   'h8, 1, 0, 0, 0, 3, 26, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h0, 'h0, 0, 27, 0,   'h8, 1, 0, 0, 0, 3, 27, 1, 3, 0, 0, C2);
        add(0, 'h8, 'h0, 'h8, 6, 28, 0,   'h8, 1, 0, 1, 6, 3, 28, 0, 3, 0, 0, C3);
        add(0, 'h0, 'h0, 'h0, 0, 0, 0,    'h0, 0, 0, 1, 6, 3, 28, 0, 3, 0, 0, C3);
        // channel 2 packet interrupted by reset on word 2
        add(0, 'h4, 'h4, 'h0, 0, 30, 0,   'h0, 0, 0, 1, 6, 3, 28, 1, 2, 0, 0, C3);
        add(0, 'h4, 'h4, 'h0, 0, 30, 0,   'h4, 1, 1, 0, 0, 2, 30, 1, 2, 0, 0, C3);
        add(1, 'h4, 'h0, 'h0, 0, 31, 0,   'h0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 64'h0);
        // all channels hold two-word packets: grant order 0,1,2,3,0
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 0, 64'h0);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h1, 1, 1, 0, 0, 0, 40, 1, 0, 0, 0, 64'h0);
        add(0, 'hF, 'hE, 'h1, 2, 41, 0,   'h1, 1, 0, 1, 2, 0, 41, 0, 0, 0, 0, R1);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h0, 0, 0, 1, 2, 0, 41, 1, 1, 0, 0, R1);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h2, 1, 1, 0, 0, 1, 40, 1, 1, 0, 0, R1);
        add(0, 'hF, 'hD, 'h2, 2, 41, 0,   'h2, 1, 0, 1, 2, 1, 41, 0, 1, 0, 0, R2);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h0, 0, 0, 1, 2, 1, 41, 1, 2, 0, 0, R2);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h4, 1, 1, 0, 0, 2, 40, 1, 2, 0, 0, R2);
        add(0, 'hF, 'hB, 'h4, 2, 41, 0,   'h4, 1, 0, 1, 2, 2, 41, 0, 2, 0, 0, R3);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h0, 0, 0, 1, 2, 2, 41, 1, 3, 0, 0, R3);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h8, 1, 1, 0, 0, 3, 40, 1, 3, 0, 0, R3);
        add(0, 'hF, 'h7, 'h8, 2, 41, 0,   'h8, 1, 0, 1, 2, 3, 41, 0, 3, 0, 0, R4);
        add(0, 'hF, 'hF, 'h0, 0, 40, 0,   'h0, 0, 0, 1, 2, 3, 41, 1, 0, 0, 0, R4);

        foreach (vecs[r]) begin
            @(negedge clk_156m25);
            drive(vecs[r].rst, vecs[r].val, vecs[r].sop, vecs[r].eop, vecs[r].mod, vecs[r].dat, vecs[r].full);
            #1;
            check("ch_rdy", r, 64'(ch_rdy), 64'(vecs[r].rdy));
            @(posedge clk_156m25);
            #1;
            check("pkt_tx_val", r, 64'(pkt_tx_val), 64'(vecs[r].tv));
            check("pkt_tx_sop", r, 64'(pkt_tx_sop), 64'(vecs[r].ts));
            check("pkt_tx_eop", r, 64'(pkt_tx_eop), 64'(vecs[r].te));
            check("pkt_tx_mod", r, 64'(pkt_tx_mod), 64'(vecs[r].tm));
            check("pkt_tx_data", r, pkt_tx_data, mk(vecs[r].dch, vecs[r].dd));
            check("grant_vld", r, 64'(grant_vld), 64'(vecs[r].gv));
            check("grant_ch", r, 64'(grant_ch), 64'(vecs[r].gch));
            check("err_nosop", r, 64'(err_nosop), 64'(vecs[r].nos));
            check("err_sop", r, 64'(err_sop), 64'(vecs[r].es));
            check("pkt_cnt", r, pkt_cnt, vecs[r].cnt);
        end

        // Channel 0 holds the grant but stalls: grant stays, nothing is sent.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk_156m25);
            drive(0, 'h0, 'h0, 'h0, 0, 0, 0);
            #1;
            check("stall_rdy", 100 + k, 64'(ch_rdy), 64'h1);
            @(posedge clk_156m25);
            #1;
            check("stall_gv", 100 + k, 64'(grant_vld), 64'h1);
            check("stall_gch", 100 + k, 64'(grant_ch), 64'h0);
            check("stall_val", 100 + k, 64'(pkt_tx_val), 64'h0);
        end
        // Single-word packet (sop and eop together) completes the held grant.
        @(negedge clk_156m25);
        drive(0, 'h1, 'h1, 'h1, 0, 50, 0);
        @(posedge clk_156m25);
        #1;
        check("single_val", 200, 64'(pkt_tx_val), 64'h1);
        check("single_sop", 200, 64'(pkt_tx_sop), 64'h1);
        check("single_eop", 200, 64'(pkt_tx_eop), 64'h1);
        check("single_mod", 200, 64'(pkt_tx_mod), 64'h0);
        check("single_data", 200, pkt_tx_data, mk(0, 50));
        check("single_gv", 200, 64'(grant_vld), 64'h0);
        check("single_esop", 200, 64'(err_sop), 64'h0);
        check("single_cnt", 200, pkt_cnt, 64'h0001_0001_0001_0002);
        @(negedge clk_156m25);
        drive(0, 'h0, 'h0, 'h0, 0, 0, 0);
        @(posedge clk_156m25);
        #1;
        check("after_val", 201, 64'(pkt_tx_val), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xgemac_tx_pkt_arbiter.md
Name: xgemac_tx_pkt_arbiter

Overview:
- Parametrised N-channel packet arbiter in front of the XGEMAC packet-transmit interface (pkt_tx_*), in the 156.25 MHz domain.
- Grants one channel at a time on packet boundaries, round-robin.
- Forwards the granted channel's words to the MAC with registered outputs and honours MAC backpressure (pkt_tx_full).
- Detects and reports framing errors on the channel inputs.

Parameters:
- NUM_CH, 4, number of input channels (2..16).
- DATA_W, 64, packet data width.
- MOD_W, 3, byte-valid modulus width (0 = all 8 bytes valid on eop).
- CNT_W, 16, width of per-channel sent-packet counters.

Ports:
- clk_156m25  in  1  core clock.
- reset_156m25  in  1  synchronous, active-high reset.
- ch_val  in  NUM_CH  per-channel word valid.
- ch_sop  in  NUM_CH  per-channel start of packet.
- ch_eop  in  NUM_CH  per-channel end of packet.
- ch_mod  in  NUM_CH*MOD_W  per-channel modulus; channel i at [i*MOD_W +: MOD_W].
- ch_data  in  NUM_CH*DATA_W  per-channel data; channel i at [i*DATA_W +: DATA_W].
- ch_rdy  out  NUM_CH  per-channel accept; a word transfers when ch_val[i] & ch_rdy[i].
- pkt_tx_val  out  1  word valid to MAC.
- pkt_tx_sop  out  1  start of packet to MAC.
- pkt_tx_eop  out  1  end of packet to MAC.
- pkt_tx_mod  out  MOD_W  modulus to MAC.
- pkt_tx_data  out  DATA_W  data to MAC.
- pkt_tx_full  in  1  MAC transmit FIFO full (backpressure).
- grant_vld  out  1  a channel currently holds the grant.
- grant_ch  out  $clog2(NUM_CH)  granted channel index.
- err_nosop  out  1  one-cycle pulse: a non-sop word was dropped while idle.
- err_sop  out  1  one-cycle pulse: sop seen mid-packet on the granted channel.
- pkt_cnt  out  NUM_CH*CNT_W  per-channel completed-packet counters.

Behaviour:
- Reset (synchronous, sampled on the rising edge of clk_156m25) forces:
  - all outputs to 0;
  - state to IDLE;
  - last_grant to NUM_CH-1, so channel 0 has first priority.
- States:
  - IDLE, no grant.
  - BUSY, grant held by grant_ch.
- IDLE:
  - Candidates are channels with ch_val & ch_sop.
  - If any candidate exists, pick the first one searching from last_grant+1 upward, wrapping modulo NUM_CH.
  - Register grant_ch, set grant_vld=1 and move to BUSY next cycle. No data transfers in the grant cycle.
  - Channels with ch_val & ~ch_sop get ch_rdy=1 and their word is discarded. err_nosop pulses the next cycle, once per cycle regardless of how many channels dropped.
- BUSY:
  - ch_rdy[grant_ch] = ~pkt_tx_full; all other ch_rdy = 0.
  - On each transfer, the output registers load val=1, sop, eop, data, and mod = eop ? ch_mod : 0. Latency is 1 cycle.
  - In any cycle without a transfer, pkt_tx_val=0 next cycle and the other pkt_tx_* fields hold their values.
- Transfer with eop:
  - last_grant <= grant_ch, pkt_cnt[grant_ch] increments (wraps at 2^CNT_W), grant_vld <= 0, go to IDLE.
  - Back-to-back packets therefore have a 1-cycle gap.
- Transfer with sop and not the first word of the packet: the word is forwarded unchanged and err_sop pulses the next cycle. The grant is kept until eop.
- Single-word packet (sop & eop in the same word): forwarded, counted, and the arbiter returns to IDLE.
- pkt_tx_full: sampled combinationally into ch_rdy. With full asserted no new word is accepted. At most one word already registered is still presented; the MAC FIFO provides that margin.
- ch_val deasserting mid-packet: no transfer, grant held indefinitely. There is no timeout.
- Reset mid-packet: the grant and the in-flight word are lost, pkt_tx_val=0 the next cycle, counters clear.

Test Plan:
- Channel 1 only: 3-word packet (sop, -, eop with mod=5) -> after the 1-cycle grant, pkt_tx shows 3 consecutive valid words 1 cycle after acceptance, last word mod=5, earlier words mod=0; pkt_cnt[1]=1.
- All 4 channels hold a 2-word packet continuously after reset -> grant order 0,1,2,3,0; each packet is contiguous on pkt_tx with no interleaving.
- pkt_tx_full asserted for 4 cycles in the middle of an 8-word packet -> ch_rdy low for those 4 cycles, no word lost or duplicated, 8 valid output words in order.
- Channel 2 drives val without sop while idle -> the word is dropped, err_nosop pulses once, pkt_tx_val stays 0.
- Second sop on word 3 of a 5-word packet on channel 0 -> all 5 words forwarded, err_sop pulses once, pkt_cnt[0]=1.
- Reset asserted on word 2 of a 4-word packet -> outputs 0 next cycle, grant_vld=0, pkt_cnt all 0; channel 0 wins the next arbitration.
